// File: rtl/xadc_drp_scheduler_pkg.sv
// Shared widths, FSM encoding and channel-selection helper for the XADC DRP
// read scheduler and its per-channel averagers.
package xadc_drp_scheduler_pkg;

  localparam int DRP_AW   = 7;
  localparam int ADC_W    = 12;
  localparam int DATA_LSB = 4;
  localparam int MAX_CH   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_NEXT  = 2'd3;

  typedef logic [ADC_W-1:0] adc_sample_t;

  // Lowest set bit of mask at index >= lo; result is {found, index}.
  function automatic logic [2:0] pick_ch(input logic [MAX_CH-1:0] mask, input logic [2:0] lo);
    logic [2:0] res;
    res = 3'b000;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= lo)) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xadc_ch_avg.sv
// Per-channel accumulator: sums 2^AVG_LOG2 accepted samples, then publishes
// the truncated mean with a one-cycle valid strobe.
module xadc_ch_avg
  import xadc_drp_scheduler_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  adc_sample_t sample,
  output adc_sample_t data,
  output logic        valid
);

  localparam int AW = ADC_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_r;
  logic [AW-1:0] sum_s;
  logic [CW-1:0] cnt_r;
  adc_sample_t   data_r;
  logic          valid_r;

  assign sum_s = acc_r + AW'(sample);

  // Accumulate accepted samples; on the last one publish and restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r   <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      data_r  <= {ADC_W{1'b0}};
      valid_r <= 1'b0;
    end else if (accept && (cnt_r == CNT_LAST)) begin
      data_r  <= ADC_W'(sum_s >> AVG_LOG2);
      valid_r <= 1'b1;
      acc_r   <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (accept) begin
      acc_r   <= sum_s;
      cnt_r   <= cnt_r + CW'(1);
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Walks the enabled aux channels on every XADC end-of-conversion, issuing one
// DRP read per channel and feeding the results to per-channel averagers.
module xadc_drp_scheduler
  import xadc_drp_scheduler_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter logic [DRP_AW-1:0] BASE_ADDR = 7'h10,
  parameter int                AVG_LOG2  = 2,
  parameter int                TIMEOUT   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EOC,
  input  logic [NUM_CH-1:0]       CH_EN,
  output logic [DRP_AW-1:0]       DRP_DADDR,
  output logic                    DRP_DEN,
  output logic                    DRP_DWE,
  input  logic [15:0]             DRP_DO,
  input  logic                    DRP_DRDY,
  output logic [ADC_W*NUM_CH-1:0] DATA,
  output logic [NUM_CH-1:0]       DATA_VALID,
  output logic                    SEQ_BUSY,
  output logic                    TMO_ERR,
  output logic                    OVR_ERR
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state_r, state_nxt_s;
  logic [1:0]        ch_r, ch_nxt_s;
  logic [NUM_CH-1:0] en_r, en_nxt_s;
  logic              pending_r, pending_nxt_s;
  logic [TW-1:0]     tmr_r;
  logic [DRP_AW-1:0] daddr_r;
  logic              den_r, busy_r, tmo_r, ovr_r;
  logic              tmo_set_s, ovr_set_s;
  logic [2:0]        first_s, next_s;
  logic [NUM_CH-1:0] acc_en_s;
  logic              unused_do_s;

  assign first_s     = pick_ch(MAX_CH'(CH_EN), 3'd0);
  assign next_s      = pick_ch(MAX_CH'(en_r), {1'b0, ch_r} + 3'd1);
  assign unused_do_s = ^DRP_DO[DATA_LSB-1:0];

  // Next-state, queued-EOC and error-set decisions.
  always_comb begin
    state_nxt_s   = state_r;
    ch_nxt_s      = ch_r;
    en_nxt_s      = en_r;
    pending_nxt_s = pending_r;
    tmo_set_s     = 1'b0;
    ovr_set_s     = 1'b0;
    if ((state_r != ST_IDLE) && EOC) begin
      if (pending_r) begin
        ovr_set_s = 1'b1;
      end else begin
        pending_nxt_s = 1'b1;
      end
    end else begin
      ovr_set_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (EOC || pending_r) begin
          en_nxt_s      = CH_EN;
          pending_nxt_s = EOC && pending_r;
          if (first_s[2]) begin
            ch_nxt_s    = first_s[1:0];
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (DRP_DRDY) begin
          state_nxt_s = ST_NEXT;
        end else if (tmr_r == TMR_LAST) begin
          tmo_set_s   = 1'b1;
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_NEXT: begin
        if (next_s[2]) begin
          ch_nxt_s    = next_s[1:0];
          state_nxt_s = ST_ISSUE;
        end else if (pending_r) begin
          // A queued EOC chains straight into the next sequence.
          en_nxt_s      = CH_EN;
          pending_nxt_s = EOC;
          ovr_set_s     = 1'b0;
          if (first_s[2]) begin
            ch_nxt_s    = first_s[1:0];
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Scheduler state and registered DRP/status outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      ch_r      <= 2'd0;
      en_r      <= {NUM_CH{1'b0}};
      pending_r <= 1'b0;
      tmr_r     <= {TW{1'b0}};
      daddr_r   <= {DRP_AW{1'b0}};
      den_r     <= 1'b0;
      busy_r    <= 1'b0;
      tmo_r     <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ch_r      <= ch_nxt_s;
      en_r      <= en_nxt_s;
      pending_r <= pending_nxt_s;
      den_r     <= (state_nxt_s == ST_ISSUE);
      busy_r    <= (state_nxt_s != ST_IDLE);
      tmo_r     <= tmo_r | tmo_set_s;
      ovr_r     <= ovr_r | ovr_set_s;
      if (state_nxt_s == ST_ISSUE) begin
        daddr_r <= BASE_ADDR + DRP_AW'(ch_nxt_s);
      end
      if (state_r == ST_ISSUE) begin
        tmr_r <= {TW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        tmr_r <= tmr_r + TW'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign acc_en_s[k] = (state_r == ST_WAIT) && DRP_DRDY && (ch_r == 2'(k));

    xadc_ch_avg #(
      .AVG_LOG2(AVG_LOG2)
    ) u_avg (
      .clk   (CLK),
      .rst_n (RST),
      .accept(acc_en_s[k]),
      .sample(DRP_DO[DATA_LSB +: ADC_W]),
      .data  (DATA[k*ADC_W +: ADC_W]),
      .valid (DATA_VALID[k])
    );
  end

  assign DRP_DADDR = daddr_r;
  assign DRP_DEN   = den_r;
  assign DRP_DWE   = 1'b0;
  assign SEQ_BUSY  = busy_r;
  assign TMO_ERR   = tmo_r;
  assign OVR_ERR   = ovr_r;

endmodule
